// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the framed UART transmit arbiter.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HDR_WAIT,
        FETCH,
        PL_WAIT,
        CHK,
        CHK_WAIT
    } state_t;

    localparam int unsigned HDR_CH_BITS      = 3;
    localparam logic [7:0]  HDR_BASE_DEFAULT = 8'hA0;

    function automatic logic [7:0] xor8(input logic [7:0] a, input logic [7:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_ptr, cyclically.
module rr_pick
    import uart_frame_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = last_ptr;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = IDX_W'((32'(last_ptr) + i) % NUM_CH);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin shares one UART transmitter between NUM_CH byte streams,
// wrapping each packet as header, payload and XOR checksum.
module uart_tx_frame_arbiter
    import uart_frame_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter logic [7:0]  HDR_BASE    = HDR_BASE_DEFAULT,
    parameter int unsigned GAP_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_valid,
    input  logic [8*NUM_CH-1:0] ch_data,
    input  logic [NUM_CH-1:0]   ch_last,
    output logic [NUM_CH-1:0]   ch_ready,
    output logic [NUM_CH-1:0]   grant,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_busy,
    output logic                abort
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam int unsigned GAP_W = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last_ptr;
    logic [7:0]         chk;
    logic [GAP_W-1:0]   gap_cnt;
    logic               pl_last;

    logic [NUM_CH-1:0]  pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [7:0]         pick_hdr;
    logic [7:0]         sel_byte;
    logic               any_req;
    logic               hs;
    logic               wait_done;
    logic               gap_hit;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req      (ch_valid),
        .last_ptr (last_ptr),
        .gnt      (pick_gnt),
        .idx      (pick_idx)
    );

    assign any_req   = |ch_valid;
    assign pick_hdr  = HDR_BASE | 8'(HDR_CH_BITS'(pick_idx));
    assign hs        = |(ch_valid & ch_ready);
    // tx_start still high means the transmitter has not yet had a chance to raise busy
    assign wait_done = !tx_start && !tx_busy;
    assign gap_hit   = (gap_cnt == GAP_W'(GAP_TIMEOUT - 1));

    // Byte mux for the granted channel (last_ptr tracks the current owner).
    always_comb begin
        sel_byte = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (last_ptr == IDX_W'(i)) begin
                sel_byte = ch_data[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (any_req) state_nxt = HDR;
            HDR:      if (!tx_busy) state_nxt = HDR_WAIT;
            HDR_WAIT: if (wait_done) state_nxt = FETCH;
            FETCH: begin
                if (hs) begin
                    state_nxt = PL_WAIT;
                end else if (gap_hit) begin
                    state_nxt = CHK;
                end
            end
            PL_WAIT:  if (wait_done) state_nxt = pl_last ? CHK : FETCH;
            CHK:      state_nxt = CHK_WAIT;
            CHK_WAIT: if (wait_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic: only the granted channel is offered ready, and only while fetching.
    always_comb begin
        ch_ready = (state == FETCH) ? grant : '0;
    end

    // Registered datapath; chk holds the header until the first payload byte folds in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant    <= '0;
            abort    <= 1'b0;
            last_ptr <= IDX_W'(NUM_CH - 1);
            chk      <= '0;
            gap_cnt  <= '0;
            pl_last  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            abort    <= 1'b0;
            unique case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (any_req) begin
                        grant    <= pick_gnt;
                        last_ptr <= pick_idx;
                        chk      <= pick_hdr;
                    end
                end
                // holds off a transmitter still draining a byte started before reset
                HDR: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= chk;
                    end
                end
                FETCH: begin
                    if (hs) begin
                        tx_start <= 1'b1;
                        tx_data  <= sel_byte;
                        chk      <= xor8(chk, sel_byte);
                        pl_last  <= ch_last[last_ptr];
                        gap_cnt  <= '0;
                    end else if (gap_hit) begin
                        chk     <= ~chk;
                        abort   <= 1'b1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                CHK: begin
                    tx_start <= 1'b1;
                    tx_data  <= chk;
                end
                CHK_WAIT: begin
                    if (wait_done) grant <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter with a simple busy-model transmitter.
module tb_uart_tx_frame_arbiter;

    localparam int unsigned NUM_CH = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_CH-1:0]   ch_valid = '0;
    logic [8*NUM_CH-1:0] ch_data = '0;
    logic [NUM_CH-1:0]   ch_last = '0;
    logic [NUM_CH-1:0]   ch_ready;
    logic [NUM_CH-1:0]   grant;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_busy;
    logic                abort;

    int checks = 0;
    int errors = 0;

    logic [7:0]        byte_q[$];
    logic [NUM_CH-1:0] gnt_q[$];
    int   viol_busy  = 0;
    int   viol_adj   = 0;
    int   viol_ready = 0;
    int   abort_cnt  = 0;
    int   busy_cnt   = 0;
    logic prev_start = 1'b0;

    always #5 clk = ~clk;

    assign tx_busy = (busy_cnt != 0);

    uart_tx_frame_arbiter #(
        .NUM_CH      (NUM_CH),
        .HDR_BASE    (8'hA0),
        .GAP_TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .ch_last  (ch_last),
        .ch_ready (ch_ready),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .abort    (abort)
    );

    // Transmitter model (busy rises the cycle after start) plus protocol monitor.
    always @(posedge clk) begin
        if (tx_start) begin
            busy_cnt <= 3;
            byte_q.push_back(tx_data);
            gnt_q.push_back(grant);
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (tx_start && tx_busy) viol_busy <= viol_busy + 1;
        if (tx_start && prev_start) viol_adj <= viol_adj + 1;
        if ((|(ch_ready & ~grant)) || ($countones(ch_ready) > 1)) viol_ready <= viol_ready + 1;
        if (abort) abort_cnt <= abort_cnt + 1;
        prev_start <= tx_start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic [7:0] d, input logic l);
        ch_valid[ch]       = v;
        ch_data[8*ch +: 8] = d;
        ch_last[ch]        = l;
    endtask

    // Waits for ch_ready on ch, lets the handshake edge pass, reports tx_start/tx_data after it.
    task automatic send_byte(input int ch, input int max, output bit ok, output logic st,
                             output logic [7:0] d);
        ok = 1'b0;
        st = 1'b0;
        d  = '0;
        for (int n = 0; n < max; n++) begin
            if (ch_ready[ch]) begin
                tick();
                ok = 1'b1;
                st = tx_start;
                d  = tx_data;
                ch_valid[ch] = 1'b0;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            if (grant == '0) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (ch_ready !== 4'b0000) begin errors++; $display("FAIL reset_ch_ready: got %b expected 0000", ch_ready); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", abort); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_channel();
        logic [7:0] exp [4] = '{8'hA0, 8'h11, 8'h22, 8'h93};
        int base = byte_q.size();
        bit ok;
        logic st;
        logic [7:0] d, got;
        drive(0, 1'b1, 8'h11, 1'b0);
        tick();
        checks++; if (grant !== 4'b0001 || tx_start !== 1'b0) begin errors++; $display("FAIL single_arb: grant %b start %b expected 0001 0", grant, tx_start); end
        tick();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hA0) begin errors++; $display("FAIL single_hdr_start: start %b data %h expected 1 A0", tx_start, tx_data); end
        send_byte(0, 20, ok, st, d);
        checks++; if (!ok || st !== 1'b1 || d !== 8'h11) begin errors++; $display("FAIL single_pl0: ok %0b start %b data %h expected 1 1 11", ok, st, d); end
        drive(0, 1'b1, 8'h22, 1'b1);
        send_byte(0, 20, ok, st, d);
        checks++; if (!ok || st !== 1'b1 || d !== 8'h22) begin errors++; $display("FAIL single_pl1: ok %0b start %b data %h expected 1 1 22", ok, st, d); end
        drive(0, 1'b0, 8'h00, 1'b0);
        wait_idle(40, ok);
        checks++; if (!ok || grant !== 4'b0000) begin errors++; $display("FAIL single_end_grant: got %b expected 0000", grant); end
        checks++; if (byte_q.size() - base != 4) begin errors++; $display("FAIL single_len: got %0d expected 4", byte_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            got = 8'hxx;
            if (base + i < byte_q.size()) got = byte_q[base + i];
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_contention();
        logic [7:0]        exp [12] = '{8'hA1, 8'h01, 8'hA0, 8'hA2, 8'h02, 8'hA0,
                                        8'hA3, 8'h30, 8'h93, 8'hA1, 8'h10, 8'hB1};
        logic [NUM_CH-1:0] eg  [12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100,
                                        4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0010};
        int base;
        bit ok;
        logic st;
        logic [7:0] d, got;
        logic [NUM_CH-1:0] gg;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        base = byte_q.size();
        drive(1, 1'b1, 8'h01, 1'b1);
        drive(2, 1'b1, 8'h02, 1'b1);
        send_byte(1, 40, ok, st, d);
        checks++; if (!ok || d !== 8'h01) begin errors++; $display("FAIL cont_ch1_pl: ok %0b data %h expected 1 01", ok, d); end
        send_byte(2, 60, ok, st, d);
        checks++; if (!ok || d !== 8'h02) begin errors++; $display("FAIL cont_ch2_pl: ok %0b data %h expected 1 02", ok, d); end
        wait_idle(40, ok);
        drive(1, 1'b1, 8'h10, 1'b1);
        drive(3, 1'b1, 8'h30, 1'b1);
        send_byte(3, 40, ok, st, d);
        send_byte(1, 60, ok, st, d);
        wait_idle(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_idle: grant %b expected 0000", grant); end
        checks++; if (byte_q.size() - base != 12) begin errors++; $display("FAIL cont_len: got %0d expected 12", byte_q.size() - base); end
        for (int i = 0; i < 12; i++) begin
            got = 8'hxx;
            gg  = 'x;
            if (base + i < byte_q.size()) begin
                got = byte_q[base + i];
                gg  = gnt_q[base + i];
            end
            checks++; if (got !== exp[i] || gg !== eg[i]) begin errors++; $display("FAIL cont_byte%0d: got %h/%b expected %h/%b", i, got, gg, exp[i], eg[i]); end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] exp [3] = '{8'hA3, 8'h00, 8'hA3};
        int base = byte_q.size();
        bit ok;
        logic st;
        logic [7:0] d, got;
        drive(3, 1'b1, 8'h00, 1'b1);
        send_byte(3, 40, ok, st, d);
        checks++; if (!ok || st !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL onebyte_pl: ok %0b start %b data %h expected 1 1 00", ok, st, d); end
        wait_idle(40, ok);
        checks++; if (byte_q.size() - base != 3) begin errors++; $display("FAIL onebyte_len: got %0d expected 3", byte_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            got = 8'hxx;
            if (base + i < byte_q.size()) got = byte_q[base + i];
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL onebyte_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp [3] = '{8'hA0, 8'h55, 8'h0A};
        int base = byte_q.size();
        int ab0 = abort_cnt;
        int stalls = 0;
        bit seen = 1'b0;
        bit ok;
        logic st;
        logic [7:0] d, got;
        drive(0, 1'b1, 8'h55, 1'b0);
        send_byte(0, 40, ok, st, d);
        for (int n = 0; n < 60; n++) begin
            if (abort) begin
                seen = 1'b1;
                break;
            end
            if (ch_ready[0]) stalls++;
            tick();
        end
        checks++; if (!seen) begin errors++; $display("FAIL timeout_abort_seen: got 0 expected 1"); end
        checks++; if (stalls != 8) begin errors++; $display("FAIL timeout_stalls: got %0d expected 8", stalls); end
        tick();
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL timeout_abort_pulse: got %b expected 0", abort); end
        wait_idle(40, ok);
        checks++; if (abort_cnt - ab0 != 1) begin errors++; $display("FAIL timeout_abort_count: got %0d expected 1", abort_cnt - ab0); end
        checks++; if (byte_q.size() - base != 3) begin errors++; $display("FAIL timeout_len: got %0d expected 3", byte_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            got = 8'hxx;
            if (base + i < byte_q.size()) got = byte_q[base + i];
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL timeout_byte%0d: got %h expected %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_mid_payload();
        logic [7:0] exp [3] = '{8'hA0, 8'h11, 8'hB1};
        int base;
        bit ok;
        logic st;
        logic [7:0] d, got;
        logic [NUM_CH-1:0] gg;
        drive(0, 1'b1, 8'h77, 1'b0);
        send_byte(0, 40, ok, st, d);
        rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx: start %b data %h expected 0 00", tx_start, tx_data); end
        checks++; if (grant !== 4'b0000 || ch_ready !== 4'b0000) begin errors++; $display("FAIL midrst_grant_ready: %b %b expected 0000 0000", grant, ch_ready); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL midrst_abort: got %b expected 0", abort); end
        base = byte_q.size();
        drive(0, 1'b1, 8'h11, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        send_byte(0, 40, ok, st, d);
        checks++; if (!ok || d !== 8'h11) begin errors++; $display("FAIL midrst_pl: ok %0b data %h expected 1 11", ok, d); end
        wait_idle(40, ok);
        checks++; if (byte_q.size() - base != 3) begin errors++; $display("FAIL midrst_len: got %0d expected 3", byte_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            got = 8'hxx;
            gg  = 'x;
            if (base + i < byte_q.size()) begin
                got = byte_q[base + i];
                gg  = gnt_q[base + i];
            end
            checks++; if (got !== exp[i] || gg !== 4'b0001) begin errors++; $display("FAIL midrst_byte%0d: got %h/%b expected %h/0001", i, got, gg, exp[i]); end
        end
    endtask

    task automatic test_handshake();
        tick();
        checks++; if (viol_busy != 0) begin errors++; $display("FAIL hs_start_while_busy: got %0d expected 0", viol_busy); end
        checks++; if (viol_adj != 0) begin errors++; $display("FAIL hs_adjacent_start: got %0d expected 0", viol_adj); end
        checks++; if (viol_ready != 0) begin errors++; $display("FAIL hs_ready_not_granted: got %0d expected 0", viol_ready); end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_contention();
        test_single_byte();
        test_timeout();
        test_reset_mid_payload();
        test_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_arbiter.md
# uart_tx_frame_arbiter

Shares one byte-wide UART transmitter between `NUM_CH` independent byte-stream requesters. It grants one channel at a time, round-robin, and wraps that channel's packet in a frame: header byte, payload bytes, XOR checksum. It sequences the transmitter through its start/busy handshake and sits between the firmware's status/telemetry sources and the `uart_tx` instance.

## Interface
- `NUM_CH`, 4: requester count, 2..8.
- `HDR_BASE`, 8'hA0: header byte is `HDR_BASE | ch_index`; low 3 bits of `HDR_BASE` must be 0.
- `GAP_TIMEOUT`, 1024: maximum idle cycles allowed mid-packet before the frame is aborted.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ch_valid`  in  NUM_CH  per-channel byte valid.
- `ch_data`  in  8*NUM_CH  per-channel byte; channel i occupies bits [8i+7:8i].
- `ch_last`  in  NUM_CH  marks the final payload byte of a packet.
- `ch_ready`  out  NUM_CH  byte accepted when `ch_valid[i] & ch_ready[i]`.
- `grant`  out  NUM_CH  one-hot owner of the current frame; zero when idle.
- `tx_start`  out  1  single-cycle start pulse to the UART transmitter.
- `tx_data`  out  8  byte to the transmitter; stable from `tx_start` until the next `tx_start`.
- `tx_busy`  in  1  transmitter busy. It rises the cycle after `tx_start`.
- `abort`  out  1  single-cycle pulse when a frame is terminated by timeout.

## Operation
- States: IDLE, HDR, HDR_WAIT, FETCH, PL_WAIT, CHK, CHK_WAIT.
- IDLE: if any `ch_valid` is set, pick the next valid channel after `last_ptr`, cyclically, and set `grant`, `last_ptr` and `chk <= header`. Then go to HDR.
- HDR and CHK: assert `tx_start` with `tx_data` = header or checksum, then go to the matching `_WAIT` state.
- Any `_WAIT` state: stay for at least one cycle after the start pulse, then leave on the first cycle where `tx_busy` = 0.
  - HDR_WAIT goes to FETCH.
  - PL_WAIT goes to FETCH, or to CHK if the accepted byte had `ch_last` set.
  - CHK_WAIT goes to IDLE and clears `grant`.
- FETCH: `ch_ready[g]` = 1 (combinational, granted channel only). On handshake:
  - register `tx_data <= byte`, `chk <= chk ^ byte`, `tx_start <= 1`;
  - go to PL_WAIT.
- The gap counter counts FETCH cycles without a handshake. When it reaches `GAP_TIMEOUT`, load `~chk` as the checksum, pulse `abort`, and go to CHK.
- A header or checksum equal to any value is sent unmodified; there is no byte stuffing.
- A new request never pre-empts the current frame. Channels not granted always see `ch_ready` = 0.
- `ch_valid` dropping mid-packet only stalls FETCH; the timeout rule still applies.

## Timing
- Reset values:
  - `tx_start` = 0, `tx_data` = 0, `ch_ready` = 0, `grant` = 0, `abort` = 0;
  - state IDLE, `last_ptr` = NUM_CH-1 so channel 0 wins first, gap counter 0, `chk` 0.
- Reset mid-frame drops the frame immediately. The transmitter finishes any byte already started; no further bytes are issued.
- Arbitration to first `tx_start`: 2 cycles (IDLE to HDR registered, then pulse).
- Payload handshake at cycle t gives `tx_start` at t+1.
- `tx_start` is never high on two consecutive cycles, and never high while `tx_busy` = 1.
- Back-to-back frames: CHK_WAIT leaves on `tx_busy` = 0, then IDLE arbitrates on the next cycle.
- Round-robin grant order is stable for requests that are simultaneous in the same cycle.

## Structure
- Shared package `uart_frame_pkg`:
  - state enum;
  - `HDR_CH_BITS` = 3;
  - default `HDR_BASE`;
  - checksum function `xor8`.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and `last_ptr`; outputs are the one-hot grant and the index.
- The `uart_tx` transmitter is instantiated by the parent, not inside this block.

## Test plan
- Single channel: ch0 sends 0x11, then 0x22 with last -> UART bytes A0, 11, 22, 93; `grant` = 0001 then 0000.
- Contention: after reset, ch1 and ch2 request in the same cycle -> frames with headers A1 then A2, no interleaving. A second simultaneous request after that -> ch3 or ch1, per pointer order.
- Handshake: model a transmitter with `tx_busy` delayed by 1 cycle -> exactly one `tx_start` per byte, none while busy, none on adjacent cycles.
- Timeout (`GAP_TIMEOUT` = 8): ch0 sends 0x55, then `ch_valid` held low -> `abort` pulses after 8 stalled FETCH cycles; bytes A0, 55, then checksum 0x0A (= ~(A0^55)).
- Reset mid-payload: `rst_n` low during PL_WAIT -> all outputs at reset values in the same cycle; the next frame starts with header A0 from ch0.
- Single-byte packet: ch3 sends 0x00 with last -> A3, 00, A3.
